// File: rtl/keypad_pkg.sv
// Shared constants for the 4x4 keypad scanner and its PicoBlaze ports.
// Holds FSM encodings, column reset pattern, port ids and key helpers.
package keypad_pkg;

  localparam int KEY_W = 4;

  localparam logic [3:0] COL_RESET = 4'b1110;

  localparam logic [7:0] KEY_PORT      = 8'h06;
  localparam logic [7:0] KEY_STAT_PORT = 8'h07;

  localparam logic [1:0] ST_IDLE     = 2'd0;
  localparam logic [1:0] ST_DEBOUNCE = 2'd1;
  localparam logic [1:0] ST_HELD     = 2'd2;

  // Status byte read on KEY_STAT_PORT.
  function automatic logic [7:0] key_status(
    input logic ovr,
    input logic vld
  );
    return {6'b0, ovr, vld};
  endfunction

  // {found, index} of the lowest set bit; index is {col, row}.
  // Scans downward so the lowest index is the last one written.
  function automatic logic [KEY_W:0] first_key(
    input logic [15:0] snap
  );
    logic [KEY_W:0] res;
    res = '0;
    for (int i = 15; i >= 0; i--) begin
      if (snap[i]) begin
        res = {1'b1, 4'(i)};
      end
    end
    return res;
  endfunction

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchronizer for a bus of independent async inputs.
// Ports: clk, reset (async active-low), d (async in), q (synced out).
module sync_2ff #(
  parameter int         W       = 4,
  parameter logic [W-1:0] RST_VAL = '1
) (
  input  logic         clk,
  input  logic         reset,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);

  logic [W-1:0] meta;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      meta <= RST_VAL;
      q    <= RST_VAL;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/keypad_scan_ctrl.sv
// 4x4 keypad column scanner, debouncer and single-entry key holding reg.
// Ports: clk, reset (async low), row_in, col_out, key_code, key_valid,
//        key_ack (pop strobe), overrun (sticky dropped-key flag).
module keypad_scan_ctrl
  import keypad_pkg::*;
#(
  parameter int SCAN_DIV       = 100000,
  parameter int DEBOUNCE_SCANS = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [3:0]       row_in,
  output logic [3:0]       col_out,
  output logic [KEY_W-1:0] key_code,
  output logic             key_valid,
  input  logic             key_ack,
  output logic             overrun
);

  localparam int DIV_W = (SCAN_DIV > 2) ? $clog2(SCAN_DIV) : 1;
  localparam int CNT_W = $clog2(DEBOUNCE_SCANS + 1);

  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(SCAN_DIV - 1);
  localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(DEBOUNCE_SCANS);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  logic [3:0]       row_s;
  logic [DIV_W-1:0] div_cnt;
  logic [1:0]       col_idx;
  logic [15:0]      snap;
  logic [15:0]      snap_n;
  logic             tick;
  logic             scan_done;

  logic [KEY_W:0]   first;
  logic             hit;
  logic [KEY_W-1:0] code;

  logic [1:0]       state, state_n;
  logic [KEY_W-1:0] cand, cand_n;
  logic [CNT_W-1:0] cnt, cnt_n, cnt_inc;
  logic [CNT_W-1:0] rel, rel_n, rel_inc;
  logic             push;

  sync_2ff #(
    .W       (4),
    .RST_VAL (4'hF)
  ) u_row_sync (
    .clk   (clk),
    .reset (reset),
    .d     (row_in),
    .q     (row_s)
  );

  assign tick      = (div_cnt == DIV_LAST);
  assign scan_done = tick && (col_idx == 2'd3);

  // Snapshot including this cycle's sample, so the col 3 tick
  // evaluates the scan it just completed.
  always_comb begin
    snap_n = snap;
    if (tick) begin
      snap_n[{col_idx, 2'b00} +: 4] = ~row_s;
    end
  end

  assign first = first_key(snap_n);
  assign hit   = first[KEY_W];
  assign code  = first[KEY_W-1:0];

  assign cnt_inc = (cnt == CNT_MAX) ? cnt : cnt + CNT_ONE;
  assign rel_inc = (rel == CNT_MAX) ? rel : rel + CNT_ONE;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      div_cnt <= '0;
      col_idx <= '0;
      col_out <= COL_RESET;
      snap    <= '0;
    end else begin
      snap <= snap_n;
      if (tick) begin
        div_cnt <= '0;
        col_idx <= col_idx + 2'd1;
        col_out <= {col_out[2:0], col_out[3]};
      end else begin
        div_cnt <= div_cnt + DIV_W'(1);
      end
    end
  end

  always_comb begin
    state_n = state;
    cand_n  = cand;
    cnt_n   = cnt;
    rel_n   = rel;
    push    = 1'b0;
    if (scan_done) begin
      case (state)
        ST_IDLE: begin
          if (hit) begin
            cand_n = code;
            cnt_n  = CNT_ONE;
            if (CNT_ONE == CNT_MAX) begin
              push    = 1'b1;
              rel_n   = '0;
              state_n = ST_HELD;
            end else begin
              state_n = ST_DEBOUNCE;
            end
          end
        end
        ST_DEBOUNCE: begin
          if (!hit) begin
            cnt_n   = '0;
            state_n = ST_IDLE;
          end else if (code == cand) begin
            cnt_n = cnt_inc;
            if (cnt_inc == CNT_MAX) begin
              push    = 1'b1;
              rel_n   = '0;
              state_n = ST_HELD;
            end
          end else begin
            cand_n = code;
            cnt_n  = CNT_ONE;
          end
        end
        ST_HELD: begin
          if (hit) begin
            rel_n = '0;
          end else if (rel_inc == CNT_MAX) begin
            rel_n   = '0;
            cnt_n   = '0;
            state_n = ST_IDLE;
          end else begin
            rel_n = rel_inc;
          end
        end
        default: begin
          cnt_n   = '0;
          rel_n   = '0;
          state_n = ST_IDLE;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= ST_IDLE;
      cand  <= '0;
      cnt   <= '0;
      rel   <= '0;
    end else begin
      state <= state_n;
      cand  <= cand_n;
      cnt   <= cnt_n;
      rel   <= rel_n;
    end
  end

  // A pop in the push cycle frees the slot for the new key.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      key_code  <= '0;
      key_valid <= 1'b0;
      overrun   <= 1'b0;
    end else if (push) begin
      if (!key_valid || key_ack) begin
        key_code  <= cand_n;
        key_valid <= 1'b1;
      end else begin
        overrun <= 1'b1;
      end
    end else if (key_ack && key_valid) begin
      key_valid <= 1'b0;
      overrun   <= 1'b0;
    end
  end

endmodule

// File: tb/tb_keypad_scan_ctrl.sv
// Directed bench for keypad_scan_ctrl with a behavioural keypad matrix.
// Uses SCAN_DIV=4 and DEBOUNCE_SCANS=2, so one scan is 16 cycles.
module tb_keypad_scan_ctrl;

  logic        clk;
  logic        reset;
  logic [3:0]  row_in;
  logic [3:0]  col_out;
  logic [3:0]  key_code;
  logic        key_valid;
  logic        key_ack;
  logic        overrun;
  logic [15:0] pressed;

  int n_cmp;
  int n_bad;

  keypad_scan_ctrl #(
    .SCAN_DIV       (4),
    .DEBOUNCE_SCANS (2)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .row_in    (row_in),
    .col_out   (col_out),
    .key_code  (key_code),
    .key_valid (key_valid),
    .key_ack   (key_ack),
    .overrun   (overrun)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always_comb begin
    row_in = 4'hF;
    for (int c = 0; c < 4; c++) begin
      for (int r = 0; r < 4; r++) begin
        if (pressed[c*4+r] && !col_out[c]) begin
          row_in[r] = 1'b0;
        end
      end
    end
  end

  task automatic check(
    input string       tag,
    input logic [31:0] got,
    input logic [31:0] exp
  );
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h", tag, got, exp);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic pulse_ack();
    key_ack = 1'b1;
    cyc(1);
    key_ack = 1'b0;
  endtask

  task automatic wait_valid(input int limit, output int n);
    n = 0;
    while (!key_valid && n < limit) begin
      cyc(1);
      n++;
    end
  endtask

  task automatic wait_ovr(input int limit);
    int n;
    n = 0;
    while (!overrun && n < limit) begin
      cyc(1);
      n++;
    end
  endtask

  // Returns #1 after the edge where col 0 becomes driven again.
  task automatic align_scan();
    logic [3:0] prev;
    logic       ok;
    ok   = 1'b0;
    prev = col_out;
    for (int i = 0; i < 40 && !ok; i++) begin
      cyc(1);
      if (prev == 4'b0111 && col_out == 4'b1110) ok = 1'b1;
      prev = col_out;
    end
    check("align", {31'b0, ok}, 32'd1);
  endtask

  task automatic watch_no_valid(input int n, output logic seen);
    seen = 1'b0;
    for (int i = 0; i < n; i++) begin
      cyc(1);
      if (key_valid) seen = 1'b1;
    end
  endtask

  int   lat;
  logic seen;

  initial begin
    n_cmp   = 0;
    n_bad   = 0;
    reset   = 1'b0;
    key_ack = 1'b0;
    pressed = '0;

    // 1: reset values and column rotation
    cyc(3);
    check("rst_col", col_out, 4'b1110);
    check("rst_vld", key_valid, 1'b0);
    check("rst_ovr", overrun, 1'b0);
    check("rst_code", key_code, 4'h0);
    @(negedge clk);
    reset = 1'b1;
    cyc(4);
    check("rot_4", col_out, 4'b1101);
    cyc(8);
    check("rot_12", col_out, 4'b0111);
    cyc(4);
    check("rot_16", col_out, 4'b1110);

    // 2: single press (1,2), ack, no auto-repeat
    cyc(5);
    pressed[6] = 1'b1;
    wait_valid(60, lat);
    check("t2_vld", key_valid, 1'b1);
    check("t2_code", key_code, 4'h6);
    check("t2_lat", {31'b0, lat <= 51}, 32'd1);
    pulse_ack();
    check("t2_ack", key_valid, 1'b0);
    watch_no_valid(48, seen);
    check("t2_norep", seen, 1'b0);
    pressed = '0;
    cyc(64);

    // 3: one-scan bounce on (0,0) is rejected
    align_scan();
    pressed[0] = 1'b1;
    cyc(16);
    pressed[0] = 1'b0;
    watch_no_valid(160, seen);
    check("t3_bounce", seen, 1'b0);
    pressed[1] = 1'b1;
    wait_valid(60, lat);
    check("t3_vld", key_valid, 1'b1);
    check("t3_code", key_code, 4'h1);
    pulse_ack();
    pressed = '0;
    cyc(64);

    // 4: second key dropped while register full
    pressed[0] = 1'b1;
    wait_valid(60, lat);
    pressed = '0;
    cyc(64);
    pressed[5] = 1'b1;
    wait_ovr(80);
    check("t4_code", key_code, 4'h0);
    check("t4_vld", key_valid, 1'b1);
    check("t4_ovr", overrun, 1'b1);
    pressed = '0;
    cyc(64);
    pulse_ack();
    check("t4_ack_vld", key_valid, 1'b0);
    check("t4_ack_ovr", overrun, 1'b0);

    // 5: ack in the exact push cycle of (3,3)
    pressed[0] = 1'b1;
    wait_valid(60, lat);
    pressed = '0;
    cyc(64);
    align_scan();
    pressed[15] = 1'b1;
    cyc(31);
    check("t5_pre_code", key_code, 4'h0);
    check("t5_pre_vld", key_valid, 1'b1);
    pulse_ack();
    check("t5_code", key_code, 4'hF);
    check("t5_vld", key_valid, 1'b1);
    check("t5_ovr", overrun, 1'b0);
    pressed = '0;
    cyc(64);
    pulse_ack();

    // 6: multi-key priority, then reset mid-debounce
    pressed[9] = 1'b1;
    pressed[3] = 1'b1;
    wait_valid(60, lat);
    check("t6_vld", key_valid, 1'b1);
    check("t6_code", key_code, 4'h3);
    pulse_ack();
    pressed = '0;
    cyc(64);
    align_scan();
    pressed[4] = 1'b1;
    cyc(17);
    reset = 1'b0;
    #1;
    check("t6_rst_col", col_out, 4'b1110);
    check("t6_rst_vld", key_valid, 1'b0);
    check("t6_rst_ovr", overrun, 1'b0);
    check("t6_rst_code", key_code, 4'h0);
    cyc(3);
    pressed = '0;
    @(negedge clk);
    reset = 1'b1;
    watch_no_valid(80, seen);
    check("t6_nokey", seen, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/keypad_scan_ctrl.md
Name: keypad_scan_ctrl

Overview:
- Sequences the 4x4 keypad: drives one column low at a time, samples the rows, debounces, and encodes the pressed key into a 4-bit code.
- Presents the code to the PicoBlaze input port through a single-entry valid/ack holding register.
- Replaces the free-running column counter and the ad-hoc keyflag logic in the top level.
- Sits between the keypad pins and the PB input mux (key port 06, status port 07).

Parameters:
- SCAN_DIV, 100000, clk cycles each column stays driven (1 ms at 100 MHz); minimum 2.
- DEBOUNCE_SCANS, 4, consecutive identical full scans needed to accept a press or confirm a release; minimum 1.

Ports:
- clk  in  1  system clock, 100 MHz.
- reset  in  1  asynchronous, active-low reset.
- row_in  in  4  keypad rows, active-low, asynchronous to clk.
- col_out  out  4  column drive, active-low one-hot.
- key_code  out  4  accepted key, {col_idx[1:0], row_idx[1:0]}.
- key_valid  out  1  holding register full.
- key_ack  in  1  one-cycle pulse (PB read strobe on port 06); pops the holding register.
- overrun  out  1  sticky flag: a key was dropped because the holding register was full.

Behaviour:
- Reset (reset=0, async): col_out=4'b1110, key_code=0, key_valid=0, overrun=0, FSM=IDLE, all counters 0.
- row_in passes through a 2-flop synchronizer before any use, giving row_s.
- Dwell counter counts 0..SCAN_DIV-1. Its terminal cycle is the "tick".
- On each tick:
  - Sample row_s into snapshot bits [col_idx*4 +: 4], inverted so pressed=1.
  - Rotate col_out left: 1110 -> 1101 -> 1011 -> 0111 -> 1110.
- Sampling at the end of the dwell gives settle time. The sample is taken before the rotation in the same cycle.
- The tick for col_idx=3 completes a scan.
- Candidate: lowest-index set bit of the snapshot. "none" if the snapshot is 0. With multiple keys pressed, the lowest index wins.
- FSM is evaluated once per scan, on the col 3 tick, using the completed snapshot:
  - IDLE:
    - candidate present -> DEBOUNCE, cand<=code, cnt<=1.
    - If DEBOUNCE_SCANS==1, push immediately and go to HELD.
  - DEBOUNCE:
    - Same code: cnt++. When cnt reaches DEBOUNCE_SCANS, push cand and go to HELD.
    - Different code: stay in DEBOUNCE, cand<=new code, cnt<=1.
    - None: go to IDLE, cnt<=0.
  - HELD:
    - None: rel++. When rel reaches DEBOUNCE_SCANS, go to IDLE.
    - Any key: rel<=0.
    - No auto-repeat.
- Push, registered, visible the cycle after the col 3 tick:
  - key_valid=0: key_code<=cand, key_valid<=1.
  - key_valid=1 with key_ack in the same cycle: key_code<=cand, key_valid stays 1, overrun unchanged by the push.
  - key_valid=1 without key_ack: key dropped, key_code unchanged, overrun<=1.
- key_ack with no push: key_valid<=0 and overrun<=0 next cycle.
- key_ack while key_valid=0: ignored.
- Worst-case latency from a stable press to key_valid: (DEBOUNCE_SCANS+1)*4*SCAN_DIV + 3 cycles.
- Reset asserted mid-scan or mid-debounce: immediate async return to reset values. No partial key is emitted.
- Counter widths are $clog2 of their maxima. cnt and rel saturate at DEBOUNCE_SCANS.

Decomposition:
- Package keypad_pkg:
  - state encoding (IDLE, DEBOUNCE, HELD).
  - COL_RESET=4'b1110.
  - KEY_W=4.
  - PB port constants KEY_PORT=8'h06, KEY_STAT_PORT=8'h07 (status = {6'b0, overrun, key_valid}).
- One sub-module: sync_2ff, a parameterised-width 2-flop synchronizer, used for row_in.
- Dwell counter, column rotation, FSM and holding register stay in keypad_scan_ctrl.

Test Plan:
- Bench uses SCAN_DIV=4, DEBOUNCE_SCANS=2.
- Keypad model: row_in[r]=0 iff key (c,r) is pressed and col_out[c]=0.

1. Reset, and column rotation -> during reset col_out=1110, key_valid=0, overrun=0. After release, col_out=1101 after 4 cycles, 0111 after 12, 1110 after 16.
2. Press key (col 1, row 2), hold 5 scans -> key_code=4'h6, key_valid=1 within 3*16+3=51 cycles. Single key_ack pulse -> key_valid=0 next cycle. Keep holding 3 more scans -> no second valid.
3. Bounce: press (0,0) for exactly one scan then release -> key_valid stays 0 for 10 scans. Press (0,1) stable -> key_code=4'h1.
4. Overrun: press and release (0,0), then press and release (1,1), with no ack -> key_code=4'h0, key_valid=1, overrun=1. key_ack -> both 0 next cycle.
5. Ack coincident with push: key_code=4'h0 valid, assert key_ack in the exact push cycle for key (3,3) -> key_code=4'hF, key_valid=1, overrun=0.
6. Multi-key and reset: hold (2,1) and (0,3) together -> key_code=4'h3. Assert reset during a later DEBOUNCE -> outputs return to reset values at once, and no key is emitted after release.
